// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   IMEM_READ      read request (master -> slave)
//   IMEM_ADDRESS   read address, held for the whole read (master -> slave)
//   IMEM_READDATA  instruction word, valid when IMEM_BUSYWAIT=0 (slave -> master)
//   IMEM_BUSYWAIT  memory not ready yet (slave -> master)
interface instruction_fetch_unit_if;
   logic        IMEM_READ;
   logic [31:0] IMEM_ADDRESS;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT;

   modport master (output IMEM_READ, IMEM_ADDRESS, input IMEM_READDATA, IMEM_BUSYWAIT);
   modport slave  (input IMEM_READ, IMEM_ADDRESS, output IMEM_READDATA, IMEM_BUSYWAIT);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the instruction-memory read
// handshake and offers INSTRUCTION / PC_INCREMENT4 to the IF/ID register.
// Handles EX redirects (BRANCH_TAKEN/BRANCH_TARGET) and hazard stalls (STALL).
// Ports:
//   CLK, RESET           clock (rising edge), async active-low reset
//   BRANCH_TAKEN/TARGET  one-cycle redirect request from EX
//   STALL                IF/ID may not accept an instruction this cycle
//   imem                 instruction memory bus (master side)
//   INSTRUCTION          instruction offered to IF/ID
//   PC_INCREMENT4        address of offered instruction + 4
//   BUSY_WAIT            IF/ID must not capture this cycle
//   FLUSH                kill the wrong-path instruction in IF/ID
//   FETCH_FAULT          sticky misaligned-redirect flag
// Optional feature: define IF_MISALIGN_CHECK_EN to trap misaligned redirect
// targets (sticky fault + halt) instead of silently clearing the low bits.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic                             BRANCH_TAKEN,
   input  logic [31:0]                      BRANCH_TARGET,
   input  logic                             STALL,
   instruction_fetch_unit_if.master         imem,
   output logic [31:0]                      INSTRUCTION,
   output logic [31:0]                      PC_INCREMENT4,
   output logic                             BUSY_WAIT,
   output logic                             FLUSH,
   output logic                             FETCH_FAULT
);

   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] hold_instr;
   logic [31:0] pending_target;
   logic        fault;

   logic [31:0] target;
   logic        misaligned;
   logic        redirect;
   logic        done;

`ifdef IF_MISALIGN_CHECK_EN
   assign target      = BRANCH_TARGET;
   assign misaligned  = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
   assign FETCH_FAULT = fault;
`else
   assign target      = BRANCH_TARGET & ~32'h3;
   assign misaligned  = 1'b0;
   assign FETCH_FAULT = 1'b0;
`endif

   assign redirect = BRANCH_TAKEN && !misaligned;
   assign done     = !imem.IMEM_BUSYWAIT;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state          <= BOOT;
         pc             <= RESET_PC;
         hold_instr     <= '0;
         pending_target <= '0;
         fault          <= 1'b0;
      end else if (misaligned) begin
         // Trap: PC untouched, park in BOOT with the fault flag blocking exit.
         fault <= 1'b1;
         state <= BOOT;
      end else begin
         case (state)
            BOOT: begin
               if (!fault) begin
                  if (redirect) pc <= target;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (redirect) begin
                  // A busy read must finish at its own address; park the target.
                  if (!done) begin
                     pending_target <= target;
                     state          <= DRAIN;
                  end else begin
                     pc <= target;
                  end
               end else if (done) begin
                  if (STALL) begin
                     hold_instr <= imem.IMEM_READDATA;
                     state      <= HOLD;
                  end else begin
                     pc <= pc + 32'd4;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (!STALL) begin
                  pc    <= pc + 32'd4;
                  state <= FETCH;
               end
            end
            DRAIN: begin
               // Newest redirect wins, even on the completing edge.
               if (done) begin
                  pc    <= redirect ? target : pending_target;
                  state <= FETCH;
               end else if (redirect) begin
                  pending_target <= target;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   always_comb begin
      imem.IMEM_READ = 1'b0;
      INSTRUCTION    = '0;
      BUSY_WAIT      = 1'b1;
      case (state)
         FETCH: begin
            imem.IMEM_READ = 1'b1;
            INSTRUCTION    = imem.IMEM_READDATA;
            BUSY_WAIT      = imem.IMEM_BUSYWAIT | STALL | BRANCH_TAKEN;
         end
         HOLD: begin
            INSTRUCTION = hold_instr;
            BUSY_WAIT   = STALL | BRANCH_TAKEN;
         end
         DRAIN: imem.IMEM_READ = 1'b1;
         default: ;
      endcase
   end

   assign imem.IMEM_ADDRESS = pc;
   assign PC_INCREMENT4     = pc + 32'd4;
   assign FLUSH             = BRANCH_TAKEN;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. Memory model with programmable
// latency, scoreboard of expected captured instruction addresses, and a
// monitor that checks every IF/ID capture plus read-address stability.
module tb_instruction_fetch_unit;
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        BRANCH_TAKEN = 1'b0;
   logic [31:0] BRANCH_TARGET = '0;
   logic        STALL = 1'b0;
   logic [31:0] INSTRUCTION, PC_INCREMENT4;
   logic        BUSY_WAIT, FLUSH, FETCH_FAULT;

   instruction_fetch_unit_if bus();

   instruction_fetch_unit #(.RESET_PC(32'h0)) dut (
      .CLK(CLK), .RESET(RESET), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
      .STALL(STALL), .imem(bus), .INSTRUCTION(INSTRUCTION), .PC_INCREMENT4(PC_INCREMENT4),
      .BUSY_WAIT(BUSY_WAIT), .FLUSH(FLUSH), .FETCH_FAULT(FETCH_FAULT));

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int captures = 0;
   bit chk_stable = 1'b1;
   logic [31:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h14) return 32'h00A00093;
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
   endfunction

   // Memory: each read is busy for wait_cnt cycles, reloaded per read.
   int  wait_cnt = 0;
   int  fixed_lat = 0;
   bit  rand_lat = 1'b0;
   logic mem_busy;
   assign mem_busy = bus.IMEM_READ && (wait_cnt != 0);
   assign bus.IMEM_BUSYWAIT = mem_busy;
   assign bus.IMEM_READDATA = mem_word(bus.IMEM_ADDRESS);

   always @(posedge CLK) begin
      if (!bus.IMEM_READ || !mem_busy)
         wait_cnt <= rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      else
         wait_cnt <= wait_cnt - 1;
   end

   // Monitor: sampled on falling edge, between stimulus updates.
   initial begin
      bit          prev_busy = 1'b0;
      logic [31:0] prev_addr = '0;
      logic [31:0] a;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            prev_busy = 1'b0;
         end else begin
            if (prev_busy && chk_stable) begin
               chk("addr_stable", bus.IMEM_ADDRESS, prev_addr);
               chk("read_held", {31'b0, bus.IMEM_READ}, 32'd1);
            end
            prev_busy = bus.IMEM_READ && bus.IMEM_BUSYWAIT;
            prev_addr = bus.IMEM_ADDRESS;
            if (!BUSY_WAIT) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL capture: unexpected capture of %h (nothing expected)", INSTRUCTION);
               end else begin
                  a = exp_q.pop_front();
                  chk("cap_instr", INSTRUCTION, mem_word(a));
                  chk("cap_pc4", PC_INCREMENT4, a + 32'd4);
                  if (exp_q.size() == 0) exp_q.push_back(a + 32'd4);
                  captures++;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   // Redirect: the architectural stream restarts at the (aligned) target.
   task automatic br(input logic [31:0] t);
      BRANCH_TAKEN  = 1'b1;
      BRANCH_TARGET = t;
`ifdef IF_MISALIGN_CHECK_EN
      if (t[1:0] == 2'b00) begin exp_q.delete(); exp_q.push_back(t); end
`else
      exp_q.delete(); exp_q.push_back(t & ~32'h3);
`endif
   endtask

   initial begin
      int cap0;
      logic [31:0] t;
      exp_q.push_back(32'h0);
      #3;
      chk("rst_read", {31'b0, bus.IMEM_READ}, 0);
      chk("rst_addr", bus.IMEM_ADDRESS, 32'h0);
      chk("rst_instr", INSTRUCTION, 0);
      chk("rst_pc4", PC_INCREMENT4, 32'h4);
      chk("rst_busy", {31'b0, BUSY_WAIT}, 1);
      chk("rst_flush", {31'b0, FLUSH}, 0);
      chk("rst_fault", {31'b0, FETCH_FAULT}, 0);
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b1;

      // Zero-latency streaming: BOOT cycle, then 0, 4, 8.
      @(negedge CLK);
      chk("boot_busy", {31'b0, BUSY_WAIT}, 1);
      chk("boot_read", {31'b0, bus.IMEM_READ}, 0);
      for (int i = 0; i < 3; i++) begin
         step(); @(negedge CLK);
         chk("seq_addr", bus.IMEM_ADDRESS, 32'(4 * i));
         chk("seq_pc4", PC_INCREMENT4, 32'(4 * i + 4));
         chk("seq_busy", {31'b0, BUSY_WAIT}, 0);
      end

      // Latency 3: address 12 held four cycles, busy for three.
      fixed_lat = 3;
      step();
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("lat_addr", bus.IMEM_ADDRESS, 32'hC);
         chk("lat_busy", {31'b0, BUSY_WAIT}, (k < 3) ? 32'd1 : 32'd0);
         step();
      end
      @(negedge CLK);
      chk("lat_next", bus.IMEM_ADDRESS, 32'h10);

      // Stall for two cycles across completion of 0x14.
      fixed_lat = 0;
      repeat (4) step();
      STALL = 1'b1;
      @(negedge CLK);
      chk("st_addr", bus.IMEM_ADDRESS, 32'h14);
      chk("st_instr0", INSTRUCTION, 32'h00A00093);
      chk("st_busy0", {31'b0, BUSY_WAIT}, 1);
      step(); @(negedge CLK);
      chk("st_read1", {31'b0, bus.IMEM_READ}, 0);
      chk("st_instr1", INSTRUCTION, 32'h00A00093);
      chk("st_pc4", PC_INCREMENT4, 32'h18);
      step(); STALL = 1'b0; @(negedge CLK);
      chk("st_read2", {31'b0, bus.IMEM_READ}, 0);
      chk("st_instr2", INSTRUCTION, 32'h00A00093);
      chk("st_busy2", {31'b0, BUSY_WAIT}, 0);
      step(); @(negedge CLK);
      chk("st_after", bus.IMEM_ADDRESS, 32'h18);

      // Redirect to 0x100 while 0x20 is two busy cycles from done.
      step(); fixed_lat = 3;
      @(negedge CLK); chk("pre_addr", bus.IMEM_ADDRESS, 32'h1C);
      step(); step();
      br(32'h100);
      @(negedge CLK);
      chk("dr_flush", {31'b0, FLUSH}, 1);
      chk("dr_addr0", bus.IMEM_ADDRESS, 32'h20);
      step(); BRANCH_TAKEN = 1'b0;
      @(negedge CLK);
      chk("dr_flush_off", {31'b0, FLUSH}, 0);
      chk("dr_addr1", bus.IMEM_ADDRESS, 32'h20);
      chk("dr_busy1", {31'b0, BUSY_WAIT}, 1);
      step(); @(negedge CLK);
      chk("dr_addr2", bus.IMEM_ADDRESS, 32'h20);
      chk("dr_busy2", {31'b0, BUSY_WAIT}, 1);
      step(); @(negedge CLK);
      chk("dr_target", bus.IMEM_ADDRESS, 32'h100);

      // Two redirects during one drain: newest wins.
      step(); br(32'h40);
      step(); br(32'h80);
      step(); BRANCH_TAKEN = 1'b0;
      step(); @(negedge CLK);
      chk("dr2_target", bus.IMEM_ADDRESS, 32'h80);

      // Randomized traffic, including wrap at the top of the address space.
      rand_lat = 1'b1;
      cap0 = captures;
      for (int c = 0; c < 1500; c++) begin
         step();
         STALL = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) begin
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
`ifndef IF_MISALIGN_CHECK_EN
            t[1:0] = 2'($urandom_range(0, 3));
`endif
            br(t);
         end else begin
            BRANCH_TAKEN = 1'b0;
         end
      end
      step();
      BRANCH_TAKEN = 1'b0; STALL = 1'b0; rand_lat = 1'b0; fixed_lat = 0;
      chk("throughput", {31'b0, (captures - cap0) >= 100}, 1);
      repeat (6) step();

      // Misaligned redirect to 0x102.
`ifdef IF_MISALIGN_CHECK_EN
      chk_stable = 1'b0;
`endif
      br(32'h102);
      @(negedge CLK);
      chk("mis_flush", {31'b0, FLUSH}, 1);
      step(); BRANCH_TAKEN = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         chk("mis_fault", {31'b0, FETCH_FAULT}, 1);
         chk("mis_read", {31'b0, bus.IMEM_READ}, 0);
         chk("mis_busy", {31'b0, BUSY_WAIT}, 1);
         step();
      end
`else
      @(negedge CLK);
      chk("mis_addr", bus.IMEM_ADDRESS, 32'h100);
      chk("mis_fault", {31'b0, FETCH_FAULT}, 0);
      step();
`endif

      // Reset asserted in the middle of a busy read.
      fixed_lat = 3;
      step(); step();
      RESET = 1'b0;
      exp_q.delete(); exp_q.push_back(32'h0);
      #1;
      chk("mrst_read", {31'b0, bus.IMEM_READ}, 0);
      chk("mrst_addr", bus.IMEM_ADDRESS, 32'h0);
      chk("mrst_instr", INSTRUCTION, 0);
      chk("mrst_busy", {31'b0, BUSY_WAIT}, 1);
      chk("mrst_fault", {31'b0, FETCH_FAULT}, 0);
      chk_stable = 1'b1;
      step(); RESET = 1'b1;
      repeat (10) step();
      chk("mrst_addr_run", bus.IMEM_ADDRESS, 32'h8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
